// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the request legality check performed at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // A request is rejected when funct3 is not legal for the access type, when
  // a halfword/word is not naturally aligned, or when the byte address lies
  // beyond the attached memory (out_of_range is computed by the caller since
  // it depends on the memory size).
  function automatic logic lsu_req_err(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] offset,
                                       input logic       out_of_range);
    logic bad_f3;
    logic misaligned;
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:    ;
      F3_H:    misaligned = offset[0];
      F3_W:    misaligned = |offset;
      F3_BU:   bad_f3 = we;
      F3_HU: begin
        bad_f3     = we;
        misaligned = offset[0];
      end
      default: bad_f3 = 1'b1;
    endcase
    return bad_f3 | misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering between the 32-bit memory word and the core:
// load-side extract/extend and store-side merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] old_word,
  input  logic [15:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word[8*gi +: 8];
      // Each store byte comes from wdata when the access covers this lane,
      // otherwise the old memory byte is kept.
      assign store_data[8*gi +: 8] =
          (funct3 == F3_B && offset == 2'(gi))        ? wdata[7:0] :
          (funct3 == F3_H && offset[1] == 1'(gi / 2)) ? wdata[8*(gi % 2) +: 8] :
                                                        old_word[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[offset];
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  // Select the addressed lane and sign- or zero-extend it.
  always_comb begin
    load_data = 32'd0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      F3_W:    load_data = word;
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one byte-addressed request at a time mapped onto a
// word-wide memory port without byte enables (sub-word stores use RMW).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data,
  output logic                  mem_wren,
  input  logic [31:0]           mem_q
);

  lsu_state_t state_reg, state_next;

  logic                  we_reg;
  logic [2:0]            funct3_reg;
  logic [1:0]            offset_reg;
  logic [15:0]           wdata_reg;
  logic [31:0]           rsp_rdata_reg;
  logic                  rsp_err_reg;
  logic [ADDR_WIDTH-1:0] mem_address_reg;
  logic [31:0]           mem_data_reg;

  logic        accept;
  logic        req_err;
  logic        req_sw;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign accept  = req_valid & req_ready;
  assign req_err = lsu_req_err(req_we, req_funct3, req_addr[1:0],
                               |(req_addr >> (ADDR_WIDTH + 2)));
  assign req_sw  = req_we & (req_funct3 == F3_W);

  lsu_lane_align u_lane_align (
    .word       (mem_q),
    .old_word   (mem_q),
    .wdata      (wdata_reg),
    .offset     (offset_reg),
    .funct3     (funct3_reg),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and state-decoded outputs; a write is suppressed while
  // reset is high so an interrupted RMW leaves memory untouched.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_wren   = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = ~reset;
        if (accept) begin
          if (req_err)     state_next = RESP;
          else if (req_sw) state_next = WR;
          else             state_next = RD;
        end
      end
      RD:   state_next = we_reg ? WR : RESP;
      WR: begin
        mem_wren   = ~reset;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, merge word and response registers; response values only
  // change on the edge that enters RESP so they hold between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_reg          <= 1'b0;
      funct3_reg      <= 3'd0;
      offset_reg      <= 2'd0;
      wdata_reg       <= 16'd0;
      rsp_rdata_reg   <= 32'd0;
      rsp_err_reg     <= 1'b0;
      mem_address_reg <= '0;
      mem_data_reg    <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            offset_reg <= req_addr[1:0];
            wdata_reg  <= req_wdata[15:0];
            if (req_err) begin
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= 32'd0;
            end else begin
              mem_address_reg <= req_addr[ADDR_WIDTH+1:2];
              if (req_sw) mem_data_reg <= req_wdata;
            end
          end
        end
        RD: begin
          if (we_reg) begin
            mem_data_reg <= store_data;
          end else begin
            rsp_rdata_reg <= load_data;
            rsp_err_reg   <= 1'b0;
          end
        end
        WR: begin
          rsp_rdata_reg <= 32'd0;
          rsp_err_reg   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign mem_address = mem_address_reg;
  assign mem_data    = mem_data_reg;

endmodule
